// File: rtl/fabric_pkg.sv
// Shared constants and state encoding for the fabric sequencer, register block and lanes.
package fabric_pkg;

  localparam int unsigned LANES   = 15;
  localparam int unsigned SRAM_AW = 10;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StClear = 3'd1;
  localparam state_t StIssue = 3'd2;
  localparam state_t StDrain = 3'd3;
  localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/fabric_if.sv
// Sequencer-to-datapath bundle: SRAM read port plus lane control.
interface fabric_if #(
  parameter int unsigned LANES   = fabric_pkg::LANES,
  parameter int unsigned SRAM_AW = fabric_pkg::SRAM_AW
);

  logic [SRAM_AW-1:0] sram_raddr;
  logic               sram_re;
  logic               lane_clear;
  logic               lane_valid;
  logic [LANES-1:0]   lane_en;

  modport master (
    output sram_raddr,
    output sram_re,
    output lane_clear,
    output lane_valid,
    output lane_en
  );

  modport slave (
    input sram_raddr,
    input sram_re,
    input lane_clear,
    input lane_valid,
    input lane_en
  );

endinterface

// File: rtl/lane_popcount.sv
// Combinational population count of the lane-enable vector.
module lane_popcount #(
  parameter int unsigned LANES = fabric_pkg::LANES,
  parameter int unsigned CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/fabric_sequencer.sv
// Streams a strided SRAM word sequence to the vector lanes and keeps run profiling counters.
module fabric_sequencer #(
  parameter int unsigned LANES   = fabric_pkg::LANES,
  parameter int unsigned SRAM_AW = fabric_pkg::SRAM_AW
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             fabric_start,
  input  logic [31:0]      fabric_base_addr,
  input  logic [15:0]      fabric_depth,
  input  logic [7:0]       fabric_stride,
  input  logic [15:0]      fabric_lane_count,
  input  logic [LANES-1:0] fabric_lane_mask,
  fabric_if.master         lanes,
  output logic             fabric_busy,
  output logic             fabric_done,
  output logic [31:0]      cycle_count,
  output logic [31:0]      utilization_count
);
  import fabric_pkg::*;

  localparam int unsigned CW = $clog2(LANES + 1);

  state_t             state_q, state_d;
  logic               start_q;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        remain_q, remain_d;
  logic [7:0]         stride_q, stride_d;
  logic [LANES-1:0]   lane_en_q, lane_en_d, lane_en_new;
  logic               lane_valid_q;
  logic [31:0]        cyc_q, cyc_d, util_q, util_d;
  logic [32:0]        util_sum;
  logic [CW-1:0]      active_lanes;
  logic               accept, issue, counting;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{fabric_base_addr[31:SRAM_AW+2], fabric_base_addr[1:0]};

  assign accept   = (state_q == StIdle) && fabric_start && !start_q;
  // Dropping start aborts immediately, so the read of the aborting cycle is suppressed too.
  assign issue    = (state_q == StIssue) && fabric_start;
  assign counting = (state_q == StClear) || (state_q == StIssue) || (state_q == StDrain);

  always_comb begin
    lane_en_new = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_en_new[i] = fabric_lane_mask[i] && (fabric_lane_count > 16'(i));
    end
  end

  lane_popcount #(.LANES(LANES), .CW(CW)) u_popcount (
    .bits  (lane_en_q),
    .count (active_lanes)
  );

  assign util_sum = {1'b0, util_q} + 33'(active_lanes);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    stride_d  = stride_q;
    lane_en_d = lane_en_q;
    cyc_d     = cyc_q;
    util_d    = util_q;
    if (lane_valid_q) util_d = util_sum[32] ? '1 : util_sum[31:0];
    if (counting && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d    = fabric_base_addr[SRAM_AW+1:2];
          remain_d  = fabric_depth;
          stride_d  = fabric_stride;
          lane_en_d = lane_en_new;
          cyc_d     = '0;
          util_d    = '0;
          state_d   = (fabric_depth == 16'd0) ? StDone : StClear;
        end
      end
      StClear: state_d = fabric_start ? StIssue : StDrain;
      StIssue: begin
        if (!fabric_start) begin
          state_d = StDrain;
        end else begin
          addr_d   = addr_q + SRAM_AW'(stride_q);
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= StIdle;
      start_q      <= 1'b1;
      addr_q       <= '0;
      remain_q     <= '0;
      stride_q     <= '0;
      lane_en_q    <= '1;
      lane_valid_q <= 1'b0;
      cyc_q        <= '0;
      util_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= fabric_start;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      stride_q     <= stride_d;
      lane_en_q    <= lane_en_d;
      lane_valid_q <= issue;
      cyc_q        <= cyc_d;
      util_q       <= util_d;
    end
  end

  assign lanes.sram_raddr = addr_q;
  assign lanes.sram_re    = issue;
  assign lanes.lane_clear = (state_q == StClear);
  assign lanes.lane_valid = lane_valid_q;
  assign lanes.lane_en    = lane_en_q;

  assign fabric_busy       = (state_q != StIdle);
  assign fabric_done       = (state_q == StDone);
  assign cycle_count       = cyc_q;
  assign utilization_count = util_q;

endmodule

// File: tb/tb_fabric_sequencer.sv
// Directed and randomized checks of fabric_sequencer against a run-level reference model.
module tb_fabric_sequencer;
  import fabric_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b1;
  logic [31:0]      base = '0;
  logic [15:0]      depth = '0;
  logic [7:0]       stride = '0;
  logic [15:0]      lcount = '0;
  logic [LANES-1:0] lmask = '0;
  logic             busy, done;
  logic [31:0]      cyc, util;

  always #5 clk = ~clk;

  fabric_if #(.LANES(LANES), .SRAM_AW(SRAM_AW)) lanes ();

  fabric_sequencer #(.LANES(LANES), .SRAM_AW(SRAM_AW)) dut (
    .s_axi_aclk        (clk),
    .s_axi_aresetn     (rst_n),
    .fabric_start      (start),
    .fabric_base_addr  (base),
    .fabric_depth      (depth),
    .fabric_stride     (stride),
    .fabric_lane_count (lcount),
    .fabric_lane_mask  (lmask),
    .lanes             (lanes),
    .fabric_busy       (busy),
    .fabric_done       (done),
    .cycle_count       (cyc),
    .utilization_count (util)
  );

  int vectors = 0;
  int miscompares = 0;

  int unsigned      obs_addr[$];
  int unsigned      exp_addr[$];
  int               obs_re, obs_clear, obs_lv, obs_lv_bad, obs_done_k, obs_clear_k, obs_re_first;
  logic             obs_done_after, obs_busy_after;
  logic [LANES-1:0] obs_lane_en;
  int               exp_re, exp_clear, exp_done_k;
  logic [31:0]      exp_cyc, exp_util;
  logic [LANES-1:0] exp_lane_en;

  localparam int RW = SRAM_AW + 5 + LANES + 64;
  logic [RW-1:0] got_rst, want_rst;

  function automatic int addr_diffs();
    int n;
    n = (obs_addr.size() > exp_addr.size()) ? obs_addr.size() - exp_addr.size()
                                            : exp_addr.size() - obs_addr.size();
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      if (obs_addr[i] != exp_addr[i]) n++;
    return n;
  endfunction

  // Whole-run expectations straight from the behavioural rules, indexed by cycles after acceptance.
  function automatic void model(input int unsigned b, d, s, cnt, m, int ab);
    int unsigned word, on, eff, pop, n;
    bit aborted;
    word = (b / 4) % (1 << SRAM_AW);
    on   = (cnt < LANES) ? cnt : LANES;
    eff  = m & ((32'd1 << on) - 1);
    pop  = 0;
    for (int i = 0; i < LANES; i++) pop += (eff >> i) & 1;
    aborted = (d != 0) && (ab > 0) && (ab <= int'(d) + 1);
    n = aborted ? ((ab >= 2) ? ab - 2 : 0) : d;
    exp_addr.delete();
    for (int unsigned i = 0; i < n; i++) exp_addr.push_back((word + i * s) % (1 << SRAM_AW));
    exp_re      = int'(n);
    exp_clear   = (d != 0) ? 1 : 0;
    exp_done_k  = (d == 0) ? 1 : aborted ? ab + 2 : int'(d) + 3;
    exp_cyc     = (d == 0) ? 0 : aborted ? ab + 1 : d + 2;
    exp_util    = n * pop;
    exp_lane_en = eff[LANES-1:0];
  endfunction

  task automatic do_run(input int abort_k);
    logic prev_re = 1'b0;
    obs_addr.delete();
    obs_re = 0; obs_clear = 0; obs_lv = 0; obs_lv_bad = 0;
    obs_done_k = -1; obs_clear_k = -1; obs_re_first = -1;
    obs_busy_after = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == abort_k) start = 1'b0;
      if (k == 2) begin
        base = $urandom; depth = 16'($urandom); stride = 8'($urandom);
        lcount = 16'($urandom); lmask = LANES'($urandom);
      end
      #1;
      if (k == 1) obs_lane_en = lanes.lane_en;
      if (lanes.sram_re) begin
        if (obs_re_first < 0) obs_re_first = k;
        obs_re++;
        obs_addr.push_back(32'(lanes.sram_raddr));
      end
      if (lanes.lane_clear) begin obs_clear++; obs_clear_k = k; end
      if (lanes.lane_valid) obs_lv++;
      if (lanes.lane_valid !== prev_re) obs_lv_bad++;
      prev_re = lanes.sram_re;
      if (done) begin obs_done_k = k; break; end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      if (j == 0) obs_done_after = done;
      if (busy) obs_busy_after = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    #12;
    got_rst  = {lanes.sram_raddr, lanes.sram_re, lanes.lane_clear, lanes.lane_valid, busy, done,
                lanes.lane_en, cyc, util};
    want_rst = {{SRAM_AW{1'b0}}, 5'b0, {LANES{1'b1}}, 64'd0};
    vectors++;
    if (got_rst !== want_rst) begin
      miscompares++; $display("FAIL reset_values got %h want %h", got_rst, want_rst);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1; vectors++;
      if (busy !== 1'b0 || lanes.sram_re !== 1'b0) begin
        miscompares++; $display("FAIL start_held_over_reset cyc%0d busy %b re %b want 0 0", j,
                                busy, lanes.sram_re);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    base = 32'h0; depth = 16'd4; stride = 8'd1; lcount = 16'd15; lmask = 15'h7FFF;
    exp_addr.delete();
    for (int unsigned i = 0; i < 4; i++) exp_addr.push_back(i);
    do_run(0);
    vectors++;
    if (addr_diffs() != 0) begin
      miscompares++; $display("FAIL basic_addrs got %0d addrs (%0d wrong) want 0,1,2,3",
                              obs_addr.size(), addr_diffs());
    end
    vectors++;
    if (obs_clear != 1 || obs_clear_k != 1 || obs_re_first != 2) begin
      miscompares++; $display("FAIL basic_timing clear %0d@%0d first_re@%0d want 1@1 2",
                              obs_clear, obs_clear_k, obs_re_first);
    end
    vectors++;
    if (obs_lv != 4 || obs_lv_bad != 0) begin
      miscompares++; $display("FAIL basic_lane_valid got %0d (bad %0d) want 4 (bad 0)",
                              obs_lv, obs_lv_bad);
    end
    vectors++;
    if (obs_done_k != 7 || obs_done_after !== 1'b0) begin
      miscompares++; $display("FAIL basic_done at %0d after %b want 7 0", obs_done_k,
                              obs_done_after);
    end
    vectors++;
    if (cyc !== 32'd6) begin miscompares++; $display("FAIL basic_cycles got %0d want 6", cyc); end
    vectors++;
    if (util !== 32'd60) begin miscompares++; $display("FAIL basic_util got %0d want 60", util); end
    vectors++;
    if (obs_busy_after !== 1'b0) begin
      miscompares++; $display("FAIL basic_retrigger busy %b want 0", obs_busy_after);
    end
  endtask

  task automatic test_wrap();
    base = 32'h0FF8; depth = 16'd3; stride = 8'd3; lcount = 16'd15; lmask = 15'h7FFF;
    exp_addr.delete();
    exp_addr.push_back(1022); exp_addr.push_back(1); exp_addr.push_back(4);
    do_run(0);
    vectors++;
    if (addr_diffs() != 0) begin
      miscompares++; $display("FAIL wrap_addrs got %0d addrs (%0d wrong) first %0d want 1022,1,4",
                              obs_addr.size(), addr_diffs(),
                              (obs_addr.size() > 0) ? obs_addr[0] : 0);
    end
  endtask

  task automatic test_lane_en();
    base = 32'h40; depth = 16'd2; stride = 8'd1; lcount = 16'd4; lmask = 15'h7FF5;
    do_run(0);
    vectors++;
    if (obs_lane_en !== 15'h0005 || lanes.lane_en !== 15'h0005) begin
      miscompares++; $display("FAIL lane_en got %h/%h want 0005", obs_lane_en, lanes.lane_en);
    end
    vectors++;
    if (util !== 32'd4) begin miscompares++; $display("FAIL lane_en_util got %0d want 4", util); end
  endtask

  task automatic test_zero_depth();
    base = 32'h100; depth = 16'd0; stride = 8'd1; lcount = 16'd15; lmask = 15'h7FFF;
    do_run(0);
    vectors++;
    if (obs_done_k != 1 || obs_re != 0 || obs_clear != 0) begin
      miscompares++; $display("FAIL zero_depth done@%0d re %0d clear %0d want 1 0 0",
                              obs_done_k, obs_re, obs_clear);
    end
    vectors++;
    if (cyc !== 32'd0 || util !== 32'd0) begin
      miscompares++; $display("FAIL zero_depth_counters got %0d %0d want 0 0", cyc, util);
    end
  endtask

  task automatic test_abort();
    base = 32'h0; depth = 16'd100; stride = 8'd1; lcount = 16'd15; lmask = 15'h7FFF;
    do_run(6);
    vectors++;
    if (obs_re != 4) begin miscompares++; $display("FAIL abort_reads got %0d want 4", obs_re); end
    vectors++;
    if (obs_done_k != 8 || cyc !== 32'd7) begin
      miscompares++; $display("FAIL abort_drain done@%0d cycles %0d want 8 7", obs_done_k, cyc);
    end
    vectors++;
    if (obs_busy_after !== 1'b0) begin
      miscompares++; $display("FAIL abort_retrigger busy %b want 0", obs_busy_after);
    end
  endtask

  task automatic test_reset_midrun();
    int waited;
    base = 32'h0; depth = 16'd10; stride = 8'd1; lcount = 16'd3; lmask = 15'h7FFF;
    @(negedge clk); start = 1'b1;
    repeat (4) @(negedge clk);
    #1; vectors++;
    if (lanes.sram_re !== 1'b1) begin
      miscompares++; $display("FAIL midrun_in_issue re %b want 1", lanes.sram_re);
    end
    rst_n = 1'b0;
    #1;
    got_rst  = {lanes.sram_raddr, lanes.sram_re, lanes.lane_clear, lanes.lane_valid, busy, done,
                lanes.lane_en, cyc, util};
    want_rst = {{SRAM_AW{1'b0}}, 5'b0, {LANES{1'b1}}, 64'd0};
    vectors++;
    if (got_rst !== want_rst) begin
      miscompares++; $display("FAIL midrun_reset_values got %h want %h", got_rst, want_rst);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1; vectors++;
      if (busy !== 1'b0 || lanes.sram_re !== 1'b0) begin
        miscompares++; $display("FAIL midrun_no_restart cyc%0d busy %b re %b want 0 0", j, busy,
                                lanes.sram_re);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1; vectors++;
    if (busy !== 1'b1 || lanes.lane_clear !== 1'b1) begin
      miscompares++; $display("FAIL midrun_new_edge busy %b clear %b want 1 1", busy,
                              lanes.lane_clear);
    end
    waited = 0;
    while (!done && waited < 50) begin @(negedge clk); #1; waited++; end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL midrun_finish timeout got 0 want done"); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int unsigned b, d, s, cnt, m;
    int ab;
    for (int it = 0; it < 40; it++) begin
      b = $urandom; d = $urandom_range(0, 20);
      s = (it % 5 == 0) ? 0 : $urandom_range(0, 255);
      cnt = $urandom_range(0, 20); m = $urandom_range(0, (1 << LANES) - 1);
      ab = (d != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, d + 1)) : 0;
      base = b; depth = 16'(d); stride = 8'(s); lcount = 16'(cnt); lmask = LANES'(m);
      model(b, d, s, cnt, m, ab);
      do_run(ab);
      vectors++;
      if (addr_diffs() != 0 || obs_re != exp_re) begin
        miscompares++; $display("FAIL rand%0d_addrs got %0d reads (%0d wrong) want %0d", it,
                                obs_re, addr_diffs(), exp_re);
      end
      vectors++;
      if (obs_clear != exp_clear) begin
        miscompares++; $display("FAIL rand%0d_clear got %0d want %0d", it, obs_clear, exp_clear);
      end
      vectors++;
      if (obs_lv_bad != 0) begin
        miscompares++; $display("FAIL rand%0d_lane_valid got %0d skewed cycles want 0", it,
                                obs_lv_bad);
      end
      vectors++;
      if (obs_done_k != exp_done_k || obs_done_after !== 1'b0) begin
        miscompares++; $display("FAIL rand%0d_done got @%0d after %b want @%0d 0", it,
                                obs_done_k, obs_done_after, exp_done_k);
      end
      vectors++;
      if (cyc !== exp_cyc) begin
        miscompares++; $display("FAIL rand%0d_cycles got %0d want %0d", it, cyc, exp_cyc);
      end
      vectors++;
      if (util !== exp_util) begin
        miscompares++; $display("FAIL rand%0d_util got %0d want %0d", it, util, exp_util);
      end
      vectors++;
      if (obs_lane_en !== exp_lane_en) begin
        miscompares++; $display("FAIL rand%0d_lane_en got %h want %h", it, obs_lane_en,
                                exp_lane_en);
      end
      vectors++;
      if (obs_busy_after !== 1'b0) begin
        miscompares++; $display("FAIL rand%0d_retrigger busy %b want 0", it, obs_busy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_lane_en();
    test_zero_depth();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fabric_sequencer.md
FABRIC_SEQUENCER -- requirements
Module: fabric_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 15: number of hardware vector lanes.
REQ-002 SHALL have parameter SRAM_AW, default 10: weight/input SRAM word-address width.
REQ-003 SHALL have port s_axi_aclk, input, 1: single clock; all logic is on the rising edge.
REQ-004 SHALL have port s_axi_aresetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port fabric_start, input, 1: level from the register block; a rising edge requests a run.
REQ-006 SHALL have port fabric_base_addr, input, 32: byte address; bits [SRAM_AW+1:2] give the start word.
REQ-007 SHALL have port fabric_depth, input, 16: number of SRAM words to stream.
REQ-008 SHALL have port fabric_stride, input, 8: word increment per step.
REQ-009 SHALL have port fabric_lane_count, input, 16: number of enabled low-order lanes.
REQ-010 SHALL have port fabric_lane_mask, input, LANES: per-lane enable.
REQ-011 SHALL have port sram_raddr, output, SRAM_AW: shared read address to the weight and input SRAMs.
REQ-012 SHALL have port sram_re, output, 1: read enable; the SRAMs return data one cycle later.
REQ-013 SHALL have port lane_clear, output, 1: one-cycle accumulator clear to the lanes.
REQ-014 SHALL have port lane_valid, output, 1: SRAM data presented to the lanes this cycle.
REQ-015 SHALL have port lane_en, output, LANES: latched effective lane enable.
REQ-016 SHALL have port fabric_busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port fabric_done, output, 1: one-cycle completion pulse.
REQ-018 SHALL have port cycle_count, output, 32: run-length profiling counter.
REQ-019 SHALL have port utilization_count, output, 32: active lane-ops profiling counter.

Function
REQ-020 SHALL implement a state machine with states IDLE, CLEAR, ISSUE, DRAIN and DONE.
REQ-021 SHALL accept a run only in IDLE, and only on fabric_start==1 when the registered previous value was 0. A held-high start SHALL NOT retrigger a run.
REQ-022 On acceptance, the block SHALL latch the following, and later input changes SHALL be ignored until the next run:
- start word
- depth
- stride
- lane_en = fabric_lane_mask & low-order ones(min(fabric_lane_count, LANES))
REQ-023 On acceptance, cycle_count and utilization_count SHALL both clear to 0.
REQ-024 An accepted run with depth==0 SHALL go IDLE->DONE with no sram_re and no lane_clear.
REQ-025 An accepted run with depth!=0 SHALL go IDLE->CLEAR.
REQ-026 CLEAR SHALL last exactly 1 cycle, assert lane_clear=1, and then go to ISSUE.
REQ-027 ISSUE SHALL assert sram_re every cycle, drive sram_raddr = current address, step the address by stride modulo 2^SRAM_AW, and last exactly depth cycles before going to DRAIN.
REQ-028 Stride 0 SHALL be legal and SHALL re-read the same word on every step.
REQ-029 DRAIN SHALL last exactly 1 cycle and then go to DONE.
REQ-030 DONE SHALL assert fabric_done=1 for exactly 1 cycle and then go to IDLE.
REQ-031 lane_valid SHALL equal sram_re delayed by 1 cycle.
REQ-032 If fabric_start==0 is sampled in CLEAR or ISSUE, the run SHALL abort: no further sram_re, go to DRAIN, and DONE SHALL still pulse.
REQ-033 cycle_count SHALL increment by 1 in each CLEAR, ISSUE and DRAIN cycle, and SHALL hold in IDLE and DONE.
REQ-034 utilization_count SHALL add popcount(lane_en) on each lane_valid cycle, saturating at 0xFFFFFFFF.
REQ-035 cycle_count SHALL saturate at 0xFFFFFFFF.
REQ-036 The counters SHALL hold their values after DONE until the next acceptance.
REQ-037 In IDLE, sram_re, lane_clear and lane_valid SHALL be 0 and sram_raddr SHALL hold.

Reset
REQ-038 Asserting s_axi_aresetn low, including mid-run, SHALL immediately force:
- state = IDLE
- sram_raddr = 0
- sram_re, lane_clear, lane_valid, fabric_busy, fabric_done = 0
- lane_en = all ones
- cycle_count = 0, utilization_count = 0
- the start edge register = 1, so that a start held high across reset does not trigger a run
REQ-039 No SRAM read SHALL be issued in the first cycle after reset release.

Structure
REQ-040 Package fabric_pkg SHALL hold LANES, SRAM_AW and the state enumeration, shared with the register block and the lanes.
REQ-041 The block SHALL contain one sub-module, lane_popcount, a combinational LANES-bit population count used for the utilization increment.

Verification
REQ-042 Bench SHALL check the basic run:
- Stimulus: base 0x0000, depth 4, stride 1, lane_count 15, mask 0x7FFF.
- Response: CLEAR 1 cycle, then sram_raddr 0,1,2,3 on consecutive cycles; lane_valid 4 cycles; fabric_done pulses 7 cycles after acceptance; cycle_count=6; utilization_count=60.
REQ-043 Bench SHALL check address wrap:
- Stimulus: base 0x0FF8 (word 1022), depth 3, stride 3.
- Response: sram_raddr 1022, 1, 4.
REQ-044 Bench SHALL check the effective lane enable:
- Stimulus: lane_count 4, mask 0x7FF5, depth 2.
- Response: lane_en=0x0005; utilization_count=4.
REQ-045 Bench SHALL check the zero-depth run:
- Stimulus: depth 0.
- Response: fabric_done 1 cycle after acceptance; no sram_re; no lane_clear; both counters 0.
REQ-046 Bench SHALL check the abort:
- Stimulus: depth 100; fabric_start dropped at the 5th ISSUE cycle.
- Response: exactly 4 sram_re, 1 DRAIN cycle, a fabric_done pulse, and no retrigger while start stays low.
REQ-047 Bench SHALL check reset mid-run:
- Stimulus: assert reset during ISSUE of a depth-10 run while start stays high.
- Response: outputs at reset values the same cycle; no new run after release until start falls and rises again.
